// File: rtl/phase4_seq_player_if.sv
// phase4_seq_player_if: 8-bit plate bus with valid/ready handshake.
//   plate_out   : symbol presented by the master (8'h00 when not valid)
//   plate_valid : plate_out holds a valid symbol
//   plate_ready : slave accepts plate_out this cycle
interface phase4_seq_player_if;
   logic [7:0] plate_out;
   logic       plate_valid;
   logic       plate_ready;
   modport master (output plate_out, plate_valid, input plate_ready);
   modport slave  (input plate_out, plate_valid, output plate_ready);
endinterface

// File: rtl/phase4_seq_player.sv
// phase4_seq_player: plays the 3-symbol phase-4 unlock sequence onto the plate bus.
//   clk           : system clock, rising edge
//   reset         : asynchronous active-low reset
//   i_start       : single-cycle request to play the sequence (ignored while busy)
//   i_abort       : stop the play immediately (ignored when idle/done)
//   plate         : plate bus master (plate_out, plate_valid, plate_ready)
//   o_step_idx    : index of the symbol presented / next to present
//   o_busy        : play in progress
//   o_seq_done    : sticky, all three symbols transferred
//   o_seq_aborted : sticky, play ended by abort or ready-wait timeout
module phase4_seq_player #(
   parameter logic [7:0]  SEQ0       = 8'b10101010,
   parameter logic [7:0]  SEQ1       = 8'b11001100,
   parameter logic [7:0]  SEQ2       = 8'b11110000,
   parameter int unsigned GAP_CYCLES = 0,
   parameter int unsigned TIMEOUT    = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_start,
   input  logic                       i_abort,
   phase4_seq_player_if.master        plate,
   output logic [1:0]                 o_step_idx,
   output logic                       o_busy,
   output logic                       o_seq_done,
   output logic                       o_seq_aborted
);
   typedef enum logic [1:0] {IDLE, DRIVE, GAP, DONE} state_t;
   // Terminal counts; only consulted when the matching feature is enabled.
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   state_t      r_state, w_state;
   logic [7:0]  r_out, w_out;
   logic        r_valid, w_valid;
   logic [1:0]  r_step, w_step;
   logic        r_busy, w_busy;
   logic        r_done, w_done;
   logic        r_aborted, w_aborted;
   logic [15:0] r_gap_cnt, w_gap_cnt;
   logic [15:0] r_to_cnt, w_to_cnt;
   logic        w_xfer, w_timeout, w_kill;
   function automatic logic [7:0] f_seq(input logic [1:0] i);
      return (i == 2'd0) ? SEQ0 : (i == 2'd1) ? SEQ1 : SEQ2;
   endfunction
   // r_valid is high exactly in DRIVE, so it doubles as the state qualifier.
   assign w_xfer    = r_valid & plate.plate_ready;
   // Fires on the TIMEOUT-th waiting cycle; a transfer in that cycle still wins.
   assign w_timeout = (TIMEOUT != 0) && r_valid && !w_xfer && (r_to_cnt == TO_LAST);
   assign w_kill    = (r_state == DRIVE || r_state == GAP) && (i_abort || w_timeout);
   always_comb begin
      w_state   = r_state;
      w_out     = r_out;
      w_valid   = r_valid;
      w_step    = r_step;
      w_busy    = r_busy;
      w_done    = r_done;
      w_aborted = r_aborted;
      w_gap_cnt = '0;
      w_to_cnt  = '0;
      if (r_state == IDLE || r_state == DONE) begin
         if (i_start) begin
            w_state   = DRIVE;
            w_out     = SEQ0;
            w_valid   = 1'b1;
            w_step    = 2'd0;
            w_busy    = 1'b1;
            w_done    = 1'b0;
            w_aborted = 1'b0;
         end
      end else if (w_kill) begin
         // Abort beats a coincident transfer; step_idx keeps the failed step.
         w_state   = IDLE;
         w_out     = 8'h00;
         w_valid   = 1'b0;
         w_busy    = 1'b0;
         w_aborted = 1'b1;
      end else if (r_state == GAP) begin
         if (r_gap_cnt == GAP_LAST) begin
            w_state = DRIVE;
            w_out   = f_seq(r_step);
            w_valid = 1'b1;
         end else begin
            w_gap_cnt = r_gap_cnt + 16'd1;
         end
      end else if (!w_xfer) begin
         w_to_cnt = r_to_cnt + 16'd1;
      end else if (r_step == 2'd2) begin
         w_state = DONE;
         w_out   = 8'h00;
         w_valid = 1'b0;
         w_busy  = 1'b0;
         w_done  = 1'b1;
      end else begin
         w_step = r_step + 2'd1;
         if (GAP_CYCLES == 0) begin
            w_out = f_seq(r_step + 2'd1);
         end else begin
            w_state = GAP;
            w_out   = 8'h00;
            w_valid = 1'b0;
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_out     <= 8'h00;
         r_valid   <= 1'b0;
         r_step    <= 2'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_gap_cnt <= '0;
         r_to_cnt  <= '0;
      end else begin
         r_state   <= w_state;
         r_out     <= w_out;
         r_valid   <= w_valid;
         r_step    <= w_step;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_aborted <= w_aborted;
         r_gap_cnt <= w_gap_cnt;
         r_to_cnt  <= w_to_cnt;
      end
   end
   assign plate.plate_out   = r_out;
   assign plate.plate_valid = r_valid;
   assign o_step_idx        = r_step;
   assign o_busy            = r_busy;
   assign o_seq_done        = r_done;
   assign o_seq_aborted     = r_aborted;
endmodule

// File: tb/tb_phase4_seq_player.sv
// tb_phase4_seq_player: scoreboard bench for two player configurations (back-to-back, and gap/timeout).
module tb_phase4_seq_player;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
   always #5 clk = ~clk;
   phase4_seq_player_if ifa ();
   phase4_seq_player_if ifb ();
   assign ifa.plate_ready = ready;
   assign ifb.plate_ready = ready;
   logic [1:0] a_step, b_step;
   logic a_busy, a_done, a_ab, b_busy, b_done, b_ab;
   phase4_seq_player #(.GAP_CYCLES(0), .TIMEOUT(0)) dut_a (
      .clk(clk), .reset(rst_n), .i_start(start), .i_abort(abort), .plate(ifa),
      .o_step_idx(a_step), .o_busy(a_busy), .o_seq_done(a_done), .o_seq_aborted(a_ab));
   phase4_seq_player #(.GAP_CYCLES(2), .TIMEOUT(4)) dut_b (
      .clk(clk), .reset(rst_n), .i_start(start), .i_abort(abort), .plate(ifb),
      .o_step_idx(b_step), .o_busy(b_busy), .o_seq_done(b_done), .o_seq_aborted(b_ab));
   // Reference model: play = sequence running, idx = symbol position,
   // gap = idle cycles still owed before presenting idx, wt = cycles waited on ready.
   typedef struct {int play; int idx; int gap; int wt; int done; int ab;} mst_t;
   mst_t cur[2], nxt[2];
   int gapc[2] = '{0, 2};
   int toc[2] = '{0, 4};
   logic [7:0] seqv[3] = '{8'hAA, 8'hCC, 8'hF0};
   logic [9:0] q0[$], q1[$];
   int errs = 0, checks = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
      end
   endtask
   task automatic mclear();
      for (int u = 0; u < 2; u++) begin
         cur[u] = '{0, 0, 0, 0, 0, 0};
         nxt[u] = '{0, 0, 0, 0, 0, 0};
      end
      q0.delete();
      q1.delete();
   endtask
   task automatic mstep(input int u);
      mst_t c, n;
      c = cur[u];
      n = c;
      if (!rst_n) n = '{0, 0, 0, 0, 0, 0};
      else if (c.play == 0) begin
         if (start) n = '{1, 0, 0, 0, 0, 0};
      end else if (abort) begin
         n.play = 0;
         n.ab = 1;
      end else if (c.gap > 0) n.gap = c.gap - 1;
      else if (ready) begin
         if (u == 0) q0.push_back({2'(c.idx), seqv[c.idx]});
         else q1.push_back({2'(c.idx), seqv[c.idx]});
         if (c.idx == 2) begin
            n.play = 0;
            n.done = 1;
         end else begin
            n.idx = c.idx + 1;
            n.gap = gapc[u];
            n.wt = 0;
         end
      end else begin
         n.wt = c.wt + 1;
         if (toc[u] > 0 && n.wt == toc[u]) begin
            n.play = 0;
            n.ab = 1;
         end
      end
      nxt[u] = n;
   endtask
   task automatic cyc(input logic s, input logic a, input logic r);
      @(posedge clk);
      #1;
      cur = nxt;
      start = s;
      abort = a;
      ready = r;
      mstep(0);
      mstep(1);
   endtask
   task automatic mon(input int u, input logic v, input logic [7:0] o, input logic [1:0] s,
                      input logic b, input logic d, input logic ab);
      mst_t c;
      logic ev;
      logic [9:0] e;
      string p;
      c = cur[u];
      p = (u == 0) ? "a" : "b";
      ev = (c.play != 0) && (c.gap == 0);
      chk({p, "_valid"}, 32'(v), 32'(ev));
      chk({p, "_out"}, 32'(o), ev ? 32'(seqv[c.idx]) : 32'h0);
      chk({p, "_step"}, 32'(s), 32'(c.idx));
      chk({p, "_busy"}, 32'(b), 32'(c.play != 0));
      chk({p, "_done"}, 32'(d), 32'(c.done));
      chk({p, "_aborted"}, 32'(ab), 32'(c.ab));
      chk({p, "_excl"}, 32'(d & ab), 32'h0);
      if (rst_n && v && ready && !abort) begin
         if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            checks++;
            errs++;
            $display("FAIL %s_xfer got=transfer expected=none", p);
         end else begin
            if (u == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk({p, "_xfer"}, 32'({s, o}), 32'(e));
         end
      end
   endtask
   always @(negedge clk) begin
      mon(0, ifa.plate_valid, ifa.plate_out, a_step, a_busy, a_done, a_ab);
      mon(1, ifb.plate_valid, ifb.plate_out, b_step, b_busy, b_done, b_ab);
   end
   int rps[4] = '{0, 30, 80, 100};
   int rp;
   initial begin
      mclear();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_a_step", 32'(a_step), 0);
      chk("rst_b_valid", 32'(ifb.plate_valid), 0);
      rst_n = 1'b1;
      // back-to-back vs gapped play, ready held high
      cyc(1, 0, 1);
      cyc(0, 0, 1);
      chk("p1_a_out0", 32'(ifa.plate_out), 32'hAA);
      chk("p1_a_busy", 32'(a_busy), 1);
      chk("p1_b_out0", 32'(ifb.plate_out), 32'hAA);
      cyc(0, 0, 1);
      chk("p1_a_out1", 32'(ifa.plate_out), 32'hCC);
      chk("p1_a_step1", 32'(a_step), 1);
      chk("p1_b_gap_valid", 32'(ifb.plate_valid), 0);
      chk("p1_b_gap_step", 32'(b_step), 1);
      cyc(0, 0, 1);
      chk("p1_a_out2", 32'(ifa.plate_out), 32'hF0);
      chk("p1_b_gap2_out", 32'(ifb.plate_out), 0);
      cyc(0, 0, 1);
      chk("p1_a_done", 32'(a_done), 1);
      chk("p1_a_idle", 32'({a_busy, ifa.plate_valid}), 0);
      chk("p1_a_step_hold", 32'(a_step), 2);
      chk("p1_b_out1", 32'(ifb.plate_out), 32'hCC);
      repeat (4) cyc(0, 0, 1);
      chk("p1_b_done", 32'(b_done), 1);
      // backpressure on step 1
      cyc(1, 0, 1);
      cyc(0, 0, 1);
      chk("bp_done_cleared", 32'(a_done), 0);
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 0);
         chk("bp_a_hold", 32'({a_step, ifa.plate_out}), 32'({2'd1, 8'hCC}));
      end
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("bp_a_next", 32'({a_step, ifa.plate_out}), 32'({2'd2, 8'hF0}));
      repeat (3) cyc(0, 0, 1);
      // ready stuck low: b times out after 4 waiting cycles
      cyc(1, 0, 0);
      repeat (4) cyc(0, 0, 0);
      chk("to_b_still_valid", 32'(ifb.plate_valid), 1);
      cyc(0, 0, 0);
      chk("to_b_aborted", 32'(b_ab), 1);
      chk("to_b_state", 32'({b_busy, ifb.plate_valid, b_step}), 0);
      chk("to_a_waiting", 32'(ifa.plate_out), 32'hAA);
      cyc(0, 1, 0);
      cyc(1, 0, 1);
      chk("ab_a_aborted", 32'(a_ab), 1);
      cyc(0, 0, 1);
      chk("rs_b_cleared", 32'(b_ab), 0);
      chk("rs_b_out", 32'(ifb.plate_out), 32'hAA);
      // abort coincident with transfer of step 2 on a
      cyc(0, 0, 1);
      cyc(0, 1, 1);
      cyc(0, 0, 0);
      chk("ab2_a_flags", 32'({a_done, a_ab}), 32'b01);
      chk("ab2_a_step", 32'(a_step), 2);
      chk("ab2_a_idle", 32'({a_busy, ifa.plate_valid}), 0);
      chk("ab2_b_step", 32'({b_ab, b_step}), 32'b101);
      // reset while b sits in its gap
      cyc(1, 0, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      #2;
      rst_n = 1'b0;
      mclear();
      #1;
      chk("mr_b_zero", 32'({ifb.plate_valid, ifb.plate_out, b_step, b_busy, b_done, b_ab}), 0);
      chk("mr_a_zero", 32'({ifa.plate_valid, ifa.plate_out, a_step, a_busy}), 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      rst_n = 1'b1;
      cyc(1, 0, 1);
      cyc(1, 0, 1);
      chk("mr_a_replay", 32'(ifa.plate_out), 32'hAA);
      cyc(0, 0, 1);
      chk("mr_a_ign_start", 32'({a_step, ifa.plate_out}), 32'({2'd1, 8'hCC}));
      // randomized traffic
      rp = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 40 == 0) rp = rps[$urandom_range(0, 3)];
         cyc($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 99) < rp);
      end
      cyc(0, 1, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
      chk("end_q0_empty", 32'(q0.size()), 0);
      chk("end_q1_empty", 32'(q1.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
